// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with a registered read port; full/empty/almost flags come from the word count.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned AF_LEVEL = 2**ADDR_W - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [ADDR_W:0]   buf_cnt,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] CntMax = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              wr_acc, rd_acc;

  assign full         = (cnt_q == CntMax);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (32'(cnt_q) >= AF_LEVEL);
  assign almost_empty = (32'(cnt_q) <= AE_LEVEL);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // No reset on the array; a write in a reset cycle is dropped so it cannot resurface.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_addr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_addr_q  <= rd_addr_q + ADDR_W'(1);
        data_out_q <= mem[rd_addr_q];
      end
      rd_valid_q <= rd_acc;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign buf_cnt  = cnt_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (wr_en && full) || (ovf_q && !err_clr);
      udf_q <= (rd_en && empty) || (udf_q && !err_clr);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (DEPTH 16, AF 12, AE 2): table vectors, directed corner cases and
// random traffic against a queue-based reference model.
module tb_sync_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int Depth = 16;
  localparam int AfLvl = 12;
  localparam int AeLvl = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [4:0] buf_cnt;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  sync_fifo_param #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .AF_LEVEL(AfLvl),
    .AE_LEVEL(AeLvl)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .buf_cnt     (buf_cnt),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: contents as a plain queue plus the visible registered outputs.
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  typedef struct {
    bit         wr;
    logic [7:0] din;
    bit         rd;
    bit         rs;
    bit         clr;
    int         cnt;
    bit         emp;
    logic [7:0] dout;
    bit         rv;
    bit         udf;
  } vec_t;

  vec_t tbl[9];

  task automatic model_step(input bit wr, input logic [7:0] din, input bit rd, input bit rs,
                            input bit clr);
    bit is_full, is_empty;
    if (rs) begin
      mq.delete();
      m_dout = 8'h00;
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      is_full  = (mq.size() == Depth);
      is_empty = (mq.size() == 0);
      if (ErrEn) begin
        m_ovf = (wr && is_full) || (m_ovf && !clr);
        m_udf = (rd && is_empty) || (m_udf && !clr);
      end
      m_rv = rd && !is_empty;
      if (m_rv) m_dout = mq.pop_front();
      if (wr && !is_full) mq.push_back(din);
    end
  endtask

  task automatic cycle(input bit wr, input logic [7:0] din, input bit rd, input bit rs,
                       input bit clr);
    @(negedge clk);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    rst     = rs;
    err_clr = clr;
    @(posedge clk);
    model_step(wr, din, rd, rs, clr);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".buf_cnt"},  32'(buf_cnt), 32'(mq.size()));
    chk({tag, ".full"},     32'(full), 32'(mq.size() == Depth));
    chk({tag, ".empty"},    32'(empty), 32'(mq.size() == 0));
    chk({tag, ".a_full"},   32'(almost_full), 32'(mq.size() >= AfLvl));
    chk({tag, ".a_empty"},  32'(almost_empty), 32'(mq.size() <= AeLvl));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  initial begin
    // wr din rd rs clr | cnt emp dout rv udf
    tbl[0] = '{0, 8'h00, 0, 1, 0, 0, 1, 8'h00, 0, 0};
    tbl[1] = '{1, 8'hA5, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    tbl[2] = '{1, 8'h3C, 1, 0, 0, 1, 0, 8'hA5, 1, 0};
    tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 1, 8'h3C, 1, 0};
    tbl[4] = '{0, 8'h00, 1, 0, 0, 0, 1, 8'h3C, 0, ErrEn};
    tbl[5] = '{1, 8'h77, 1, 0, 0, 1, 0, 8'h3C, 0, ErrEn};
    tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 1, 8'h77, 1, ErrEn};
    tbl[7] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'h77, 0, ErrEn};
    tbl[8] = '{0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 0, 0};

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].rs, tbl[i].clr);
      chk($sformatf("tbl%0d.buf_cnt", i), 32'(buf_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d.data_out", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].udf));
    end

    // Fill and drain with flag tracking.
    cycle(0, 8'h00, 0, 1, 0);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.a_empty", 32'(almost_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(i), 0, 0, 0);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.buf_cnt", 32'(buf_cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 8'h00, 1, 0, 0);
      check_model($sformatf("drain%0d", i));
      chk($sformatf("drain%0d.value", i), 32'(data_out), 32'(i));
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Full collision: read wins, the colliding write is dropped.
    for (int i = 0; i < 16; i++) cycle(1, 8'h10 + 8'(i), 0, 0, 0);
    cycle(1, 8'hEE, 1, 0, 0);
    check_model("fullcol");
    chk("fullcol.buf_cnt", 32'(buf_cnt), 32'd15);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 8'h00, 1, 0, 0);
      check_model($sformatf("fullcol_drain%0d", i));
    end
    chk("fullcol.last", 32'(data_out), 32'h1F);

    // Wrap-around of both pointers.
    cycle(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'hA0 + 8'(i), 1, 0, 0);
      check_model($sformatf("wrap%0d", i));
    end
    cycle(0, 8'h00, 1, 0, 0);
    chk("wrap.last", 32'(data_out), 32'hAB);
    check_model("wrap_end");

    // Error flags.
    for (int i = 0; i < 16; i++) cycle(1, 8'h30 + 8'(i), 0, 0, 0);
    cycle(1, 8'h55, 0, 0, 0);
    chk("err.overflow", 32'(overflow), 32'(ErrEn));
    cycle(0, 8'h00, 0, 0, 1);
    chk("err.ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 8'h00, 1, 0, 0);
      check_model($sformatf("err_drain%0d", i));
    end
    cycle(0, 8'h00, 1, 0, 0);
    chk("err.underflow", 32'(underflow), 32'(ErrEn));
    chk("err.dout_held", 32'(data_out), 32'h3F);
    check_model("err_end");

    // Reset mid-operation with a concurrent write.
    for (int i = 0; i < 7; i++) cycle(1, 8'h60 + 8'(i), 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(1, 8'h99, 0, 1, 0);
    chk("midrst.buf_cnt", 32'(buf_cnt), 32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.data_out", 32'(data_out), 32'h00);
    chk("midrst.rd_valid", 32'(rd_valid), 32'd0);
    cycle(0, 8'h00, 1, 0, 0);
    check_model("midrst_rd");

    // Random traffic with alternating fill/drain bias.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      bit w, r, rs, cl;
      pw = ((i / 250) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < (100 - pw));
      rs = ($urandom_range(0, 399) == 0);
      cl = ($urandom_range(0, 29) == 0);
      cycle(w, 8'($urandom), r, rs, cl);
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
